// File: rtl/armleocpu_load_unit_if.sv
// Request, data-bus and response signals of the load unit.
// slave  : the load unit itself.
// master : the surrounding pipeline and data port that drive it.
interface armleocpu_load_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_type;
   logic [4:0]  req_rd;

   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        mem_rerror;

   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_exc;
   logic [1:0]  resp_cause;

   modport slave (
      input  req_valid, req_addr, req_type, req_rd,
      input  mem_ready, mem_rvalid, mem_rdata, mem_rerror,
      input  resp_ready,
      output req_ready, mem_valid, mem_addr,
      output resp_valid, resp_data, resp_rd, resp_exc, resp_cause
   );

   modport master (
      output req_valid, req_addr, req_type, req_rd,
      output mem_ready, mem_rvalid, mem_rdata, mem_rerror,
      output resp_ready,
      input  req_ready, mem_valid, mem_addr,
      input  resp_valid, resp_data, resp_rd, resp_exc, resp_cause
   );
endinterface

// File: rtl/armleocpu_load_unit.sv
// Load sequencing controller: accepts one load from execute, reads the
// containing word(s) from the data port, realigns/extends via
// armleocpu_loadgen and returns the result or an exception to writeback.
// Optional feature macro: ARMLEOCPU_LOAD_MISALIGNED_SPLIT_EN executes
// misaligned loads in hardware, splitting word-crossing ones into two reads.
package armleocpu_load_pkg;
   localparam logic [2:0] LOAD_BYTE          = 3'b000;
   localparam logic [2:0] LOAD_HALF          = 3'b001;
   localparam logic [2:0] LOAD_WORD          = 3'b010;
   localparam logic [2:0] LOAD_BYTE_UNSIGNED = 3'b100;
   localparam logic [2:0] LOAD_HALF_UNSIGNED = 3'b101;

   localparam logic [1:0] CAUSE_NONE       = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
   localparam logic [1:0] CAUSE_FAULT      = 2'b10;
   localparam logic [1:0] CAUSE_UNKNOWN    = 2'b11;
endpackage

// Realign and extend: dword_i holds {second word, first word}; for a
// single-word access the upper half is zero.
module armleocpu_loadgen
   import armleocpu_load_pkg::*;
(
   input  logic [1:0]  offset_i,
   input  logic [2:0]  type_i,
   input  logic [63:0] dword_i,
   output logic [31:0] data_o
);
   logic [31:0] shifted;

   // Move the addressed byte down to bit 0
   always_comb shifted = 32'(dword_i >> {offset_i, 3'b000});

   // Truncate to the access size and sign/zero extend
   always_comb begin
      data_o = 32'd0;
      case (type_i)
         LOAD_BYTE:          data_o = {{24{shifted[7]}}, shifted[7:0]};
         LOAD_HALF:          data_o = {{16{shifted[15]}}, shifted[15:0]};
         LOAD_WORD:          data_o = shifted;
         LOAD_BYTE_UNSIGNED: data_o = {24'd0, shifted[7:0]};
         LOAD_HALF_UNSIGNED: data_o = {16'd0, shifted[15:0]};
         default:            data_o = 32'd0;
      endcase
   end
endmodule

module armleocpu_load_unit
   import armleocpu_load_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   armleocpu_load_unit_if.slave        bus
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, RESP} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  type_q, type_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] data_q, data_d;
   logic        exc_q, exc_d;
   logic [1:0]  cause_q, cause_d;
`ifdef ARMLEOCPU_LOAD_MISALIGNED_SPLIT_EN
   logic        pass_q, pass_d;    // 1 while fetching the second word
   logic [31:0] first_q, first_d;  // first word of a crossing load
`endif

   logic        req_ready;
   logic        req_fire;
   logic [63:0] lg_dword;
   logic [31:0] lg_data;

   function automatic logic type_known(input logic [2:0] t);
      return (t == LOAD_BYTE) || (t == LOAD_HALF) || (t == LOAD_WORD) ||
             (t == LOAD_BYTE_UNSIGNED) || (t == LOAD_HALF_UNSIGNED);
   endfunction

   function automatic logic is_half(input logic [2:0] t);
      return (t == LOAD_HALF) || (t == LOAD_HALF_UNSIGNED);
   endfunction

`ifdef ARMLEOCPU_LOAD_MISALIGNED_SPLIT_EN
   // Access spills into the next word: any unaligned word, or a half at offset 3
   function automatic logic crosses(input logic [1:0] off, input logic [2:0] t);
      return ((t == LOAD_WORD) && (off != 2'b00)) || (is_half(t) && (off == 2'b11));
   endfunction
`else
   function automatic logic misaligned(input logic [1:0] off, input logic [2:0] t);
      return ((t == LOAD_WORD) && (off != 2'b00)) || (is_half(t) && off[0]);
   endfunction
`endif

   assign req_ready = (state_q == IDLE) && !flush;
   assign req_fire  = bus.req_valid && req_ready;

`ifdef ARMLEOCPU_LOAD_MISALIGNED_SPLIT_EN
   assign lg_dword = pass_q ? {bus.mem_rdata, first_q} : {32'd0, bus.mem_rdata};
`else
   assign lg_dword = {32'd0, bus.mem_rdata};
`endif

   armleocpu_loadgen u_loadgen (
      .offset_i (addr_q[1:0]),
      .type_i   (type_q),
      .dword_i  (lg_dword),
      .data_o   (lg_data)
   );

   // Next-state and response capture
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      type_d  = type_q;
      rd_d    = rd_q;
      data_d  = data_q;
      exc_d   = exc_q;
      cause_d = cause_q;
`ifdef ARMLEOCPU_LOAD_MISALIGNED_SPLIT_EN
      pass_d  = pass_q;
      first_d = first_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_fire) begin
               addr_d = bus.req_addr;
               type_d = bus.req_type;
               rd_d   = bus.req_rd;
`ifdef ARMLEOCPU_LOAD_MISALIGNED_SPLIT_EN
               pass_d = 1'b0;
`endif
               if (!type_known(bus.req_type)) begin
                  state_d = RESP;
                  data_d  = 32'd0;
                  exc_d   = 1'b1;
                  cause_d = CAUSE_UNKNOWN;
               end
`ifndef ARMLEOCPU_LOAD_MISALIGNED_SPLIT_EN
               else if (misaligned(bus.req_addr[1:0], bus.req_type)) begin
                  state_d = RESP;
                  data_d  = 32'd0;
                  exc_d   = 1'b1;
                  cause_d = CAUSE_MISALIGNED;
               end
`endif
               else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            // A flush that coincides with mem_ready still owes us a beat
            if (flush)
               state_d = bus.mem_ready ? DRAIN : IDLE;
            else if (bus.mem_ready)
               state_d = WAIT;
         end
         WAIT: begin
            if (flush) begin
               state_d = bus.mem_rvalid ? IDLE : DRAIN;
            end else if (bus.mem_rvalid) begin
               if (bus.mem_rerror) begin
                  state_d = RESP;
                  data_d  = 32'd0;
                  exc_d   = 1'b1;
                  cause_d = CAUSE_FAULT;
               end
`ifdef ARMLEOCPU_LOAD_MISALIGNED_SPLIT_EN
               else if (!pass_q && crosses(addr_q[1:0], type_q)) begin
                  state_d = ISSUE;
                  pass_d  = 1'b1;
                  first_d = bus.mem_rdata;
               end
`endif
               else begin
                  state_d = RESP;
                  data_d  = lg_data;
                  exc_d   = 1'b0;
                  cause_d = CAUSE_NONE;
               end
            end
         end
         DRAIN: begin
            if (bus.mem_rvalid)
               state_d = IDLE;
         end
         RESP: begin
            if (flush || bus.resp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and captured request/response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= 32'd0;
         type_q  <= 3'd0;
         rd_q    <= 5'd0;
         data_q  <= 32'd0;
         exc_q   <= 1'b0;
         cause_q <= CAUSE_NONE;
`ifdef ARMLEOCPU_LOAD_MISALIGNED_SPLIT_EN
         pass_q  <= 1'b0;
         first_q <= 32'd0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         type_q  <= type_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         exc_q   <= exc_d;
         cause_q <= cause_d;
`ifdef ARMLEOCPU_LOAD_MISALIGNED_SPLIT_EN
         pass_q  <= pass_d;
         first_q <= first_d;
`endif
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.mem_valid  = (state_q == ISSUE);
`ifdef ARMLEOCPU_LOAD_MISALIGNED_SPLIT_EN
   // Second pass reads the following word, wrapping at the top of memory
   assign bus.mem_addr   = (state_q == ISSUE) ?
                           ({addr_q[31:2], 2'b00} + (pass_q ? 32'd4 : 32'd0)) : 32'd0;
`else
   assign bus.mem_addr   = (state_q == ISSUE) ? {addr_q[31:2], 2'b00} : 32'd0;
`endif
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_data  = data_q;
   assign bus.resp_rd    = rd_q;
   assign bus.resp_exc   = exc_q;
   assign bus.resp_cause = cause_q;
endmodule
